fifo_rd_packer: RTL and testbench



---
 rtl/fifo_rd_packer_if.sv | 24 ++
 rtl/fifo_rd_packer.sv | 123 ++++++++++++
 tb/tb_fifo_rd_packer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_packer_if.sv
// rtl/fifo_rd_packer_if.sv - packed output word stream between packer and downstream consumer
interface fifo_rd_packer_if #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
);
    logic                     m_valid;
    logic                     m_ready;
    logic [WIDTH*RATIO-1:0]   m_data;
    logic [RATIO-1:0]         m_keep;

    modport master (
        output m_valid,
        output m_data,
        output m_keep,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_keep,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops FIFO entries and packs RATIO of them into one wide stream word
module fifo_rd_packer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rempty,
    output logic             rinc,
    input  logic [WIDTH-1:0] rdata,
    input  logic             flush,
    output logic             flush_busy,
    fifo_rd_packer_if.master m
);
    localparam int CW = $clog2(RATIO + 1);
    localparam logic [CW-1:0] FULL = CW'(RATIO);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    typedef enum logic [1:0] {
        PACK    = 2'd0,
        FL_WAIT = 2'd1,
        FL_EMIT = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   inflight;
    logic [CW-1:0]          lane_cnt;
    logic [WIDTH-1:0]       lanes [RATIO];

    logic                   out_free;
    logic                   bypass;
    logic                   stored;
    logic                   emit;
    logic                   load;
    logic [CW-1:0]          fill;
    logic [WIDTH*RATIO-1:0] load_data;
    logic [RATIO-1:0]       load_keep;

    assign out_free = !m.m_valid || m.m_ready;

    // State register: flush sequencing
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state <= PACK;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a flush drains the in-flight pop, then emits any partial word
    always_comb begin
        state_nxt = state;
        case (state)
            PACK:    if (flush) state_nxt = FL_WAIT;
            FL_WAIT: if (!inflight) state_nxt = (lane_cnt == '0) ? PACK : FL_EMIT;
            FL_EMIT: if (out_free) state_nxt = PACK;
            default: state_nxt = PACK;
        endcase
    end

    // Outputs: word-load strobes and the pop request (never over-commits the lanes)
    always_comb begin
        bypass     = (state == PACK) && inflight && (lane_cnt == LAST) && out_free;
        stored     = (state == PACK) && (lane_cnt == FULL) && out_free;
        emit       = (state == FL_EMIT) && out_free;
        load       = bypass || stored || emit;
        flush_busy = (state != PACK);
        rinc       = !rrst && (state == PACK) && !flush && !rempty &&
                     ((((CW+1)'(lane_cnt) + (CW+1)'(inflight)) < (CW+1)'(RATIO)) || bypass);
    end

    // Word to load: stored lanes, the landing entry in the top lane on bypass, zeros beyond the fill
    always_comb begin
        fill = bypass ? FULL : lane_cnt;
        for (int i = 0; i < RATIO; i++) begin
            load_keep[i] = (CW'(i) < fill);
            if (bypass && (i == RATIO - 1)) begin
                load_data[i*WIDTH +: WIDTH] = rdata;
            end else begin
                load_data[i*WIDTH +: WIDTH] = load_keep[i] ? lanes[i] : '0;
            end
        end
    end

    // Pop tracking and lane capture of the entry returned one cycle after each pop
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            inflight <= 1'b0;
            lane_cnt <= '0;
            for (int i = 0; i < RATIO; i++) begin
                lanes[i] <= '0;
            end
        end else begin
            inflight <= rinc;
            if (load) begin
                lane_cnt <= '0;
            end else if (inflight) begin
                for (int i = 0; i < RATIO; i++) begin
                    if (CW'(i) == lane_cnt) begin
                        lanes[i] <= rdata;
                    end
                end
                lane_cnt <= lane_cnt + CW'(1);
            end
        end
    end

    // Output register: held under backpressure, reloaded back-to-back when possible
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            m.m_valid <= 1'b0;
            m.m_data  <= '0;
            m.m_keep  <= '0;
        end else if (load) begin
            m.m_valid <= 1'b1;
            m.m_data  <= load_data;
            m.m_keep  <= load_keep;
        end else if (m.m_ready) begin
            m.m_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - randomized and directed bench for fifo_rd_packer against a queue model
module tb_fifo_rd_packer;
    localparam int WIDTH = 8;
    localparam int RATIO = 4;

    logic             rclk = 1'b0;
    logic             rrst = 1'b0;
    logic             rempty = 1'b1;
    logic             rinc;
    logic [WIDTH-1:0] rdata = '0;
    logic             flush = 1'b0;
    logic             flush_busy;

    fifo_rd_packer_if #(.WIDTH(WIDTH), .RATIO(RATIO)) s_if ();

    fifo_rd_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .rempty     (rempty),
        .rinc       (rinc),
        .rdata      (rdata),
        .flush      (flush),
        .flush_busy (flush_busy),
        .m          (s_if)
    );

    always #5 rclk = ~rclk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  fifo_q [$];
    logic [7:0]  pend   [$];
    logic [35:0] exp_q  [$];
    logic [35:0] acc_q  [$];
    int          acc_cyc[$];
    int          cyc = 0;
    int          pop_cnt = 0;
    int          busy_cnt = 0;
    int          valid_cnt = 0;
    logic        prev_hold = 1'b0;
    logic [35:0] prev_word = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model word built from the entries collected so far: lane i holds the i-th popped byte
    function automatic logic [35:0] pack_word();
        logic [35:0] w;
        w = '0;
        for (int i = 0; i < pend.size(); i++) begin
            w[i*8 +: 8] = pend[i];
            w[32 + i]   = 1'b1;
        end
        return w;
    endfunction

    // Compare process: values at the falling edge are what the next rising edge acts on
    always @(negedge rclk) begin
        cyc++;
        if (rrst) begin
            check("reset_outputs", {rinc, s_if.m_valid, flush_busy, s_if.m_keep, s_if.m_data}, '0);
            pend.delete();
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            check("no_pop_when_empty", rinc && rempty, 0);
            if (flush_busy) check("no_pop_in_flush", rinc, 0);
            if (prev_hold) check("hold_stable", {s_if.m_valid, s_if.m_keep, s_if.m_data}, {1'b1, prev_word});
            if (s_if.m_valid && s_if.m_ready) begin
                if (exp_q.size() == 0) begin
                    check("word_expected", exp_q.size() != 0, 1);
                end else begin
                    check("word", {s_if.m_keep, s_if.m_data}, exp_q.pop_front());
                end
                acc_q.push_back({s_if.m_keep, s_if.m_data});
                acc_cyc.push_back(cyc);
            end
            prev_hold = s_if.m_valid && !s_if.m_ready;
            prev_word = {s_if.m_keep, s_if.m_data};
            if (s_if.m_valid) valid_cnt++;
            if (flush_busy) busy_cnt++;
            if (rinc && fifo_q.size() != 0) begin
                pop_cnt++;
                pend.push_back(fifo_q[0]);
                if (pend.size() == RATIO) begin
                    exp_q.push_back(pack_word());
                    pend.delete();
                end
            end
            if (flush && !flush_busy && pend.size() != 0) begin
                exp_q.push_back(pack_word());
                pend.delete();
            end
        end
    end

    task automatic step();
        logic pop;
        @(negedge rclk);
        pop = rinc;
        @(posedge rclk);
        #1;
        if (pop && fifo_q.size() != 0) rdata = fifo_q.pop_front();
        rempty = (fifo_q.size() == 0);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        rempty = 1'b0;
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        step();
        rrst = 1'b0;
        acc_q.delete();
        acc_cyc.delete();
    endtask

    initial begin
        int p0;
        int b0;
        int v0;
        s_if.m_ready = 1'b0;
        rrst = 1'b1;
        steps(2);
        check("reset_state", {rinc, s_if.m_valid, flush_busy, s_if.m_keep, s_if.m_data}, '0);
        rrst = 1'b0;

        // Full-rate packing of 8 entries
        s_if.m_ready = 1'b1;
        acc_q.delete(); acc_cyc.delete();
        for (int i = 1; i <= 8; i++) push(8'(i));
        p0 = pop_cnt;
        steps(8);
        check("t1_pops_8_consecutive", pop_cnt - p0, 8);
        steps(8);
        check("t1_words", acc_q.size(), 2);
        if (acc_q.size() == 2) begin
            check("t1_word0", acc_q[0], {4'hF, 32'h04030201});
            check("t1_word1", acc_q[1], {4'hF, 32'h08070605});
            check("t1_word_spacing", acc_cyc[1] - acc_cyc[0], 4);
        end

        // Backpressure: lanes fill behind a held word, then both release in order
        do_reset();
        s_if.m_ready = 1'b0;
        for (int i = 1; i <= 12; i++) push(8'(i));
        p0 = pop_cnt;
        steps(20);
        check("t2_pops_stalled", pop_cnt - p0, 8);
        check("t2_held_word", {s_if.m_valid, s_if.m_keep, s_if.m_data}, {1'b1, 4'hF, 32'h04030201});
        s_if.m_ready = 1'b1;
        steps(12);
        check("t2_words", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            check("t2_word0", acc_q[0], {4'hF, 32'h04030201});
            check("t2_word1", acc_q[1], {4'hF, 32'h08070605});
            check("t2_word2", acc_q[2], {4'hF, 32'h0C0B0A09});
            check("t2_back_to_back", acc_cyc[1] - acc_cyc[0], 1);
        end

        // Partial word flush with 3 lanes
        do_reset();
        push(8'hA0); push(8'hA1); push(8'hA2);
        steps(5);
        b0 = busy_cnt;
        flush = 1'b1; step(); flush = 1'b0;
        steps(6);
        check("t3_words", acc_q.size(), 1);
        if (acc_q.size() == 1) check("t3_word", acc_q[0], {4'h7, 32'h00A2A1A0});
        check("t3_busy_cycles", busy_cnt - b0, 2);

        // Flush with nothing stored
        acc_q.delete(); acc_cyc.delete();
        v0 = valid_cnt;
        b0 = busy_cnt;
        flush = 1'b1; step(); flush = 1'b0;
        steps(4);
        check("t4_no_valid", valid_cnt - v0, 0);
        check("t4_busy_cycles", busy_cnt - b0, 1);

        // Flush in the cycle a popped entry lands
        do_reset();
        push(8'h5A); push(8'h5B);
        step();
        flush = 1'b1; step(); flush = 1'b0;
        steps(6);
        check("t5_words", acc_q.size(), 1);
        if (acc_q.size() >= 1) check("t5_word", acc_q[0], {4'h1, 32'h0000005A});
        flush = 1'b1; step(); flush = 1'b0;
        steps(6);
        check("t5_words_after", acc_q.size(), 2);
        if (acc_q.size() == 2) check("t5_word_next", acc_q[1], {4'h1, 32'h0000005B});

        // Reset with two lanes filled and one pop in flight
        do_reset();
        push(8'hC0); push(8'hC1); push(8'hC2);
        steps(3);
        rrst = 1'b1;
        #1;
        check("t6_async_reset", {rinc, s_if.m_valid, flush_busy, s_if.m_keep, s_if.m_data}, '0);
        step();
        rrst = 1'b0;
        acc_q.delete(); acc_cyc.delete();
        push(8'hD0); push(8'hD1); push(8'hD2); push(8'hD3);
        steps(10);
        check("t6_words", acc_q.size(), 1);
        if (acc_q.size() == 1) check("t6_fresh_word", acc_q[0], {4'hF, 32'hD3D2D1D0});

        // Randomized traffic, backpressure, flushes and occasional resets
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 16) push(8'($urandom));
            s_if.m_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rrst = 1'b1;
                step();
                rrst = 1'b0;
            end
            step();
        end
        flush = 1'b0;
        s_if.m_ready = 1'b1;
        steps(40);
        flush = 1'b1; step(); flush = 1'b0;
        steps(10);
        check("drain_words_left", exp_q.size(), 0);
        check("drain_entries_left", pend.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
